// File: rtl/instr_issuer.sv
// Instruction sequencer: fetches from a small writable program memory and hands
// each instruction to the control FSM with a valid/ready + done handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | after reset, waiting for start
//   S_FETCH  | latch mem[pc] into instr, decode opcode
//   S_ISSUE  | instr_valid high, instr held until the FSM accepts it
//   S_WAIT   | instruction accepted, waiting for cpu_done
//   S_PAUSE  | single-step mode, waiting for a step pulse
//   S_HALTED | run ended (HALT, illegal opcode or end of memory)
module instr_issuer #(
    parameter int OP_SIZE  = 4,
    parameter int ARG_SIZE = 3,
    parameter int ARG_NUM  = 2,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    localparam int INSTR_W = OP_SIZE + ARG_NUM * ARG_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               cpu_done,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [ADDR_W-1:0]  pc
);

    localparam logic [OP_SIZE-1:0] OP_LOAD = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] OP_MOVE = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_HALT = {OP_SIZE{1'b1}};
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_PAUSE,
        S_HALTED
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] fetch_word;
    logic [OP_SIZE-1:0] fetch_op;
    logic               fetch_legal;
    logic               fetch_halt;
    logic               run_start;

    assign fetch_word  = mem[pc];
    assign fetch_op    = fetch_word[INSTR_W-1 -: OP_SIZE];
    assign fetch_halt  = (fetch_op == OP_HALT);
    assign fetch_legal = (fetch_op == OP_LOAD) || (fetch_op == OP_MOVE) ||
                         (fetch_op == OP_ADD)  || (fetch_op == OP_XOR);
    assign run_start   = start && ((state_q == S_IDLE) || (state_q == S_HALTED));

    // Program memory has no reset so a program survives a mid-run abort.
    always_ff @(posedge clk) begin
        if (prog_we && !busy && (int'(prog_addr) < DEPTH)) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_halt || !fetch_legal) state_nxt = S_HALTED;
                else                            state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (instr_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cpu_done) begin
                    if (pc == LAST_ADDR) state_nxt = S_HALTED;
                    else if (step_mode)  state_nxt = S_PAUSE;
                    else                 state_nxt = S_FETCH;
                end
            end
            S_PAUSE: begin
                if (step) state_nxt = S_FETCH;
            end
            S_HALTED: begin
                if (start) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        instr_valid = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH:  busy = 1'b1;
            S_ISSUE: begin
                busy        = 1'b1;
                instr_valid = 1'b1;
            end
            S_WAIT:   busy = 1'b1;
            S_PAUSE:  busy = 1'b1;
            S_HALTED: halted = 1'b1;
            default: begin
                busy   = 1'b0;
                halted = 1'b0;
            end
        endcase
    end

    // pc stays on the HALT / illegal word so software can see where the run ended.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= '0;
            instr   <= '0;
            illegal <= 1'b0;
        end else begin
            if (run_start) begin
                pc      <= '0;
                illegal <= 1'b0;
            end
            if (state_q == S_FETCH) begin
                instr <= fetch_word;
                if (!fetch_halt && !fetch_legal) illegal <= 1'b1;
            end
            if ((state_q == S_WAIT) && cpu_done && (pc != LAST_ADDR)) begin
                pc <= pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Randomized scoreboard bench for instr_issuer: a reference model walks the
// program to predict the issue stream, a monitor checks every accepted instruction.
module tb_instr_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, step_mode, step, prog_we;
    logic [3:0] prog_addr;
    logic [9:0] prog_data;
    logic [9:0] instr;
    logic       instr_valid, instr_ready, cpu_done;
    logic       busy, halted, illegal;
    logic [3:0] pc;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int last_hold = 0;
    int hold_cnt = 0;
    bit outstanding = 0;
    bit was_waiting = 0;
    logic [9:0] held_instr;

    logic [9:0] model_mem [16];
    logic [9:0] exp_q [$];

    bit rand_lat = 0;
    int rdy_lat = 0;
    int done_lat = 0;
    bit cpu_busy = 0;

    int         exp_n;
    logic [3:0] exp_pc;
    logic       exp_ill;

    instr_issuer dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .cpu_done(cpu_done), .busy(busy), .halted(halted), .illegal(illegal), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [9:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        model_mem[a] = d;
        tick();
        prog_we = 1'b0;
    endtask

    function automatic logic [9:0] rand_word();
        int p;
        logic [3:0] op;
        p = $urandom_range(0, 9);
        if (p < 7)       op = 4'($urandom_range(0, 3));
        else if (p == 7) op = 4'hF;
        else             op = 4'($urandom_range(4, 14));
        return {op, 6'($urandom)};
    endfunction

    // Reference: walk memory from 0; legal words are issued, HALT/illegal/end stop the run.
    task automatic model_run();
        logic [3:0] op;
        exp_q.delete();
        exp_n = 0; exp_ill = 1'b0; exp_pc = 4'd15;
        for (int a = 0; a < 16; a++) begin
            op = model_mem[a][9:6];
            if (op == 4'hF) begin
                exp_pc = 4'(a);
                break;
            end
            if (op > 4'd3) begin
                exp_pc = 4'(a); exp_ill = 1'b1;
                break;
            end
            exp_q.push_back(model_mem[a]);
            exp_n++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_run(input string name, input bit corrupt);
        int cyc = 0;
        while (halted !== 1'b1 && cyc < 3000) begin
            tick();
            // writes/starts while busy must be ignored; the model never sees them
            if (corrupt && busy && $urandom_range(0, 3) == 0) begin
                prog_we = 1'b1; prog_addr = 4'($urandom); prog_data = 10'($urandom);
                start = 1'($urandom_range(0, 1));
            end else begin
                prog_we = 1'b0; start = 1'b0;
            end
            cyc++;
        end
        prog_we = 1'b0; start = 1'b0;
        check({name, " halted"}, 32'(halted), 32'd1);
        check({name, " pc"}, 32'(pc), 32'(exp_pc));
        check({name, " illegal"}, 32'(illegal), 32'(exp_ill));
        repeat (4) tick();
        check({name, " issues_left"}, 32'(exp_q.size()), 32'd0);
        check({name, " busy_after"}, 32'(busy), 32'd0);
    endtask

    // CPU-side model: accepts after rdy_lat cycles, pulses cpu_done done_lat cycles later.
    initial begin
        int r, d;
        instr_ready = 1'b0;
        cpu_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cpu_done = 1'b0;
            if (rst === 1'b1 && instr_valid === 1'b1) begin
                cpu_busy = 1'b1;
                r = rand_lat ? $urandom_range(0, 3) : rdy_lat;
                d = rand_lat ? $urandom_range(0, 3) : done_lat;
                repeat (r) begin @(posedge clk); #1; end
                instr_ready = 1'b1;
                @(posedge clk);
                #1;
                instr_ready = 1'b0;
                repeat (d) begin @(posedge clk); #1; end
                cpu_done = 1'b1;
                cpu_busy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                outstanding = 0; hold_cnt = 0; was_waiting = 0;
            end else begin
                if (cpu_done) outstanding = 0;
                if (instr_valid) begin
                    if (outstanding) begin
                        n_cmp++; n_err++;
                        $display("FAIL issue_before_done: instr %0h valid while previous not done", instr);
                    end
                    if (was_waiting) check("instr_stable", 32'(instr), 32'(held_instr));
                    held_instr = instr;
                    if (instr_ready) begin
                        n_acc++;
                        last_hold = hold_cnt;
                        hold_cnt = 0;
                        was_waiting = 0;
                        outstanding = 1;
                        if (exp_q.size() == 0) begin
                            n_cmp++; n_err++;
                            $display("FAIL unexpected_issue: got %0h, expected no issue", instr);
                        end else begin
                            check("issued_instr", 32'(instr), 32'(exp_q.pop_front()));
                        end
                    end else begin
                        hold_cnt++;
                        was_waiting = 1;
                    end
                end else begin
                    was_waiting = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cyc;
        rst = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst instr", 32'(instr), 32'd0);
        check("rst valid", 32'(instr_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst halted", 32'(halted), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst pc", 32'(pc), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // step in IDLE does nothing
        step = 1'b1; tick(); step = 1'b0;
        repeat (3) tick();
        check("idle_step busy", 32'(busy), 32'd0);
        check("idle_step halted", 32'(halted), 32'd0);

        // basic program; word 0 rewritten in the same cycle as start
        for (int a = 0; a < 16; a++) write_mem(4'(a), rand_word());
        write_mem(4'd0, 10'h150);
        write_mem(4'd1, 10'h04A);
        write_mem(4'd2, 10'h3C0);
        model_mem[0] = 10'h000;
        model_run();
        rand_lat = 0; rdy_lat = 0; done_lat = 0;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 10'h000;
        pulse_start();
        prog_we = 1'b0;
        @(negedge clk);
        check("t1 fetch_busy", 32'(busy), 32'd1);
        check("t1 fetch_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("t1 issue_valid", 32'(instr_valid), 32'd1);
        tick();
        finish_run("t1", 1'b0);

        // held ready low: ADD stays on the port for 5 cycles, single accept
        write_mem(4'd0, 10'h0A3);
        write_mem(4'd1, 10'h3C0);
        model_run();
        rdy_lat = 5; done_lat = 3;
        base = n_acc;
        pulse_start();
        finish_run("t2", 1'b0);
        check("t2 hold_cycles", 32'(last_hold), 32'd5);
        check("t2 accepts", 32'(n_acc - base), 32'd1);

        // illegal opcode at address 1, then a restart clears illegal
        rdy_lat = 0; done_lat = 1;
        write_mem(4'd0, 10'h000);
        write_mem(4'd1, 10'h150);
        model_run();
        pulse_start();
        finish_run("t3", 1'b0);
        model_run();
        pulse_start();
        @(negedge clk);
        check("t3 restart_illegal", 32'(illegal), 32'd0);
        check("t3 restart_halted", 32'(halted), 32'd0);
        tick();
        finish_run("t3b", 1'b0);

        // all 16 words ADD: runs off the end, no wrap
        for (int a = 0; a < 16; a++) write_mem(4'(a), {4'h2, 6'($urandom)});
        model_run();
        done_lat = 3;
        pulse_start();
        finish_run("t4", 1'b0);
        repeat (10) tick();
        check("t4 still_halted", 32'(halted), 32'd1);

        // single-step
        write_mem(4'd0, 10'h000);
        write_mem(4'd1, 10'h04A);
        write_mem(4'd2, 10'h0A3);
        write_mem(4'd3, 10'h3C0);
        model_run();
        done_lat = 1; step_mode = 1'b1;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (cpu_done !== 1'b1 && cyc < 100);
            check("t5 done_seen", 32'(cpu_done), 32'd1);
            repeat (4) tick();
            @(negedge clk);
            check("t5 paused_valid", 32'(instr_valid), 32'd0);
            check("t5 paused_busy", 32'(busy), 32'd1);
            tick();
            step = 1'b1; tick(); step = 1'b0;
        end
        finish_run("t5", 1'b0);
        step_mode = 1'b0;

        // reset while in WAIT of the second instruction
        model_run();
        done_lat = 20;
        base = n_acc;
        pulse_start();
        cyc = 0;
        while (n_acc < base + 2 && cyc < 200) begin tick(); cyc++; end
        repeat (2) tick();
        #2 rst = 1'b0;
        #1;
        check("t6 rst instr", 32'(instr), 32'd0);
        check("t6 rst valid", 32'(instr_valid), 32'd0);
        check("t6 rst busy", 32'(busy), 32'd0);
        check("t6 rst halted", 32'(halted), 32'd0);
        check("t6 rst illegal", 32'(illegal), 32'd0);
        check("t6 rst pc", 32'(pc), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b1;
        cyc = 0;
        while (cpu_busy && cyc < 100) begin tick(); cyc++; end
        repeat (3) tick();
        check("t6 idle_busy", 32'(busy), 32'd0);
        check("t6 idle_halted", 32'(halted), 32'd0);
        model_run();
        done_lat = 1;
        pulse_start();
        finish_run("t6 rerun", 1'b0);

        // randomized programs and CPU timing, with ignored writes/starts mid-run
        rand_lat = 1;
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 16; a++) write_mem(4'(a), rand_word());
            model_run();
            pulse_start();
            finish_run($sformatf("rand%0d", r), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
